// File: rtl/phi2_pkg.sv
// Shared PHI2 timing constants and state encoding, used by both the clock
// generator and the frequency measurement path.
package phi2_pkg;

   localparam int unsigned REF_HZ  = 50_000_000;
   localparam int unsigned MAX_HZ  = REF_HZ / 4;
   localparam int unsigned C64_HZ  = 1_000_000;
   localparam int unsigned C128_HZ = 2_000_000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } phi2_state_e;

   function automatic logic freq_ok(input logic [31:0] hz, input logic [31:0] max_hz);
      return (hz != '0) && (hz <= max_hz);
   endfunction

endpackage

// File: rtl/phase_accum.sv
// Modulo-WRAP_HZ phase accumulator; toggle_o marks each wrap, which is one
// half-period of the synthesized clock.
module phase_accum
   import phi2_pkg::*;
#(
   parameter int unsigned WRAP_HZ = REF_HZ
) (
   input  logic        clk_ref,
   input  logic        rst_n,
   input  logic        run_i,
   input  logic        clr_i,
   input  logic [31:0] step_i,
   output logic        toggle_o
);

   logic [31:0] acc_q;
   logic [31:0] acc_d;
   logic [31:0] sum;
   logic        wrap;

   always_comb begin
      sum      = acc_q + step_i;
      wrap     = (sum >= WRAP_HZ);
      acc_d    = acc_q;
      toggle_o = 1'b0;
      if (clr_i) begin
         acc_d = '0;
      end else if (run_i) begin
         if (wrap) begin
            acc_d    = sum - WRAP_HZ;
            toggle_o = 1'b1;
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk_ref) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/phi2_clock_gen.sv
// Glitch-free PHI2 clock synthesizer: run/drain FSM, request validation and
// a pending-frequency register that is only applied on a falling edge.
module phi2_clock_gen #(
   parameter int unsigned REF_HZ     = phi2_pkg::REF_HZ,
   parameter int unsigned DEFAULT_HZ = phi2_pkg::C64_HZ,
   parameter int unsigned MAX_HZ     = REF_HZ / 4
) (
   input  logic        clk_ref,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] freq_in,
   input  logic        freq_load,
   output logic        clk_out,
   output logic        rise_stb,
   output logic        fall_stb,
   output logic [31:0] freq_active,
   output logic        cfg_busy,
   output logic        cfg_err,
   output logic        running
);

   import phi2_pkg::*;

   phi2_state_e state_q, state_d;
   logic        clk_out_q, clk_out_d;
   logic        rise_stb_q, rise_stb_d;
   logic        fall_stb_q, fall_stb_d;
   logic [31:0] freq_q, freq_d;
   logic [31:0] pend_q, pend_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;

   logic [31:0] step;
   logic        load_ok;
   logic        load_bad;
   logic        acc_run;
   logic        acc_clr;
   logic        commit;
   logic        to_idle;
   logic        toggle;

   assign step     = freq_q << 1;
   assign load_ok  = freq_load &  freq_ok(freq_in, MAX_HZ);
   assign load_bad = freq_load & ~freq_ok(freq_in, MAX_HZ);

   // Kept outside the FSM block: toggle depends on acc_clr, so merging them
   // would create a false combinational loop through one process.
   assign acc_run = (state_q != IDLE);
   assign commit  = acc_run & fall_stb_q & busy_q;
   assign to_idle = (state_q == DRAIN) & ~en & fall_stb_q;
   assign acc_clr = (state_q == IDLE) | commit | to_idle;

   phase_accum #(
      .WRAP_HZ (REF_HZ)
   ) u_accum (
      .clk_ref  (clk_ref),
      .rst_n    (rst_n),
      .run_i    (acc_run),
      .clr_i    (acc_clr),
      .step_i   (step),
      .toggle_o (toggle)
   );

   always_comb begin
      state_d    = state_q;
      clk_out_d  = clk_out_q;
      rise_stb_d = 1'b0;
      fall_stb_d = 1'b0;
      freq_d     = freq_q;
      pend_d     = pend_q;
      busy_d     = busy_q;
      err_d      = err_q;

      if (load_bad) begin
         err_d = 1'b1;
      end else if (load_ok) begin
         err_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            clk_out_d = 1'b0;
            if (load_ok) begin
               freq_d = freq_in;
               busy_d = 1'b0;
            end else if (busy_q) begin
               freq_d = pend_q;
               busy_d = 1'b0;
            end
            if (en) begin
               state_d = RUN;
            end
         end

         RUN, DRAIN: begin
            if (toggle) begin
               clk_out_d  = ~clk_out_q;
               rise_stb_d = ~clk_out_q;
               fall_stb_d =  clk_out_q;
            end
            // Commit uses the old pending value; a same-cycle load re-arms it.
            if (commit) begin
               freq_d = pend_q;
               busy_d = 1'b0;
            end
            if (load_ok) begin
               pend_d = freq_in;
               busy_d = 1'b1;
            end
            if (state_q == RUN) begin
               if (!en) begin
                  state_d = DRAIN;
               end
            end else if (en) begin
               state_d = RUN;
            end else if (fall_stb_q) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_ref) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         clk_out_q  <= 1'b0;
         rise_stb_q <= 1'b0;
         fall_stb_q <= 1'b0;
         freq_q     <= DEFAULT_HZ;
         pend_q     <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_out_q  <= clk_out_d;
         rise_stb_q <= rise_stb_d;
         fall_stb_q <= fall_stb_d;
         freq_q     <= freq_d;
         pend_q     <= pend_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign clk_out     = clk_out_q;
   assign rise_stb    = rise_stb_q;
   assign fall_stb    = fall_stb_q;
   assign freq_active = freq_q;
   assign cfg_busy    = busy_q;
   assign cfg_err     = err_q;
   assign running     = (state_q != IDLE);

endmodule
